// File: rtl/std_dcache_init_ctrl.sv
// std_dcache_init_ctrl
// Owns the dcache valid/dirty SRAM port while clearing every line after reset,
// after a synchronous clear, or on an init request. Otherwise it passes
// arbiter accesses straight through to the SRAM with zero added latency.
// Optional build macro: DCACHE_INIT_CYCLES_EN adds init_cycles_o, a saturating
// count of all cycles spent walking since the last rst_ni.
module std_dcache_init_ctrl #(
  parameter int unsigned NumWords   = 256,
  parameter int unsigned IndexWidth = 12,
  parameter int unsigned ByteOffset = 4,
  parameter int unsigned SetAssoc   = 8,
  parameter int unsigned VdWidth    = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic                         init_ni,
  input  logic [SetAssoc-1:0]          arb_req_i,
  input  logic                         arb_we_i,
  input  logic [IndexWidth-1:0]        arb_addr_i,
  input  logic [VdWidth-1:0]           arb_wdata_i,
  input  logic [VdWidth-1:0]           arb_be_i,
  output logic                         arb_gnt_o,
  output logic                         sram_req_o,
  output logic                         sram_we_o,
  output logic [IndexWidth-ByteOffset-1:0] sram_addr_o,
  output logic [VdWidth-1:0]           sram_wdata_o,
  output logic [VdWidth-1:0]           sram_be_o,
`ifdef DCACHE_INIT_CYCLES_EN
  output logic [15:0]                  init_cycles_o,
`endif
  output logic                         busy_o,
  output logic                         init_done_o
);

  localparam int unsigned CntW  = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned AddrW = IndexWidth - ByteOffset;
  localparam logic [CntW-1:0] LastIdx = CntW'(NumWords - 1);

  typedef enum logic {INIT, IDLE} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            init_done_q;

  // Walk sequencing: clear has top priority, the last index either finishes
  // the walk or restarts it when init is still requested.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else if (clr_i) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (cnt_q == LastIdx) begin
            cnt_q <= '0;
            if (init_ni) begin
              state_q     <= IDLE;
              init_done_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (!init_ni) begin
            state_q <= INIT;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  // SRAM port mux: the walker writes zeros over the full line, else the
  // arbiter request goes through untouched.
  always_comb begin
    if (state_q == INIT) begin
      sram_req_o   = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = AddrW'(cnt_q);
      sram_wdata_o = '0;
      sram_be_o    = '1;
      arb_gnt_o    = 1'b0;
    end else begin
      sram_req_o   = |arb_req_i;
      sram_we_o    = arb_we_i;
      sram_addr_o  = arb_addr_i[IndexWidth-1:ByteOffset];
      sram_wdata_o = arb_wdata_i;
      sram_be_o    = arb_be_i;
      arb_gnt_o    = |arb_req_i;
    end
  end

  assign busy_o      = (state_q == INIT);
  assign init_done_o = init_done_q;

`ifdef DCACHE_INIT_CYCLES_EN
  logic [15:0] init_cycles_q;

  // Lifetime walk-cycle counter; survives clr_i and sticks at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_cycles_q <= '0;
    end else if (state_q == INIT && init_cycles_q != 16'hFFFF) begin
      init_cycles_q <= init_cycles_q + 16'd1;
    end
  end

  assign init_cycles_o = init_cycles_q;
`endif

endmodule

// File: tb/tb_std_dcache_init_ctrl.sv
// Directed bench for std_dcache_init_ctrl (default parameters).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_std_dcache_init_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clr_i;
  logic        init_ni;
  logic [7:0]  arb_req_i;
  logic        arb_we_i;
  logic [11:0] arb_addr_i;
  logic [63:0] arb_wdata_i;
  logic [63:0] arb_be_i;
  logic        arb_gnt_o;
  logic        sram_req_o;
  logic        sram_we_o;
  logic [7:0]  sram_addr_o;
  logic [63:0] sram_wdata_o;
  logic [63:0] sram_be_o;
  logic        busy_o;
  logic        init_done_o;
`ifdef DCACHE_INIT_CYCLES_EN
  logic [15:0] init_cycles_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  std_dcache_init_ctrl dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (clr_i),
    .init_ni      (init_ni),
    .arb_req_i    (arb_req_i),
    .arb_we_i     (arb_we_i),
    .arb_addr_i   (arb_addr_i),
    .arb_wdata_i  (arb_wdata_i),
    .arb_be_i     (arb_be_i),
    .arb_gnt_o    (arb_gnt_o),
    .sram_req_o   (sram_req_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_be_o    (sram_be_o),
`ifdef DCACHE_INIT_CYCLES_EN
    .init_cycles_o(init_cycles_o),
`endif
    .busy_o       (busy_o),
    .init_done_o  (init_done_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {req, we, busy, gnt, wdata==0, be all-ones, addr}
  function automatic logic [13:0] walk_vec();
    return {sram_req_o, sram_we_o, busy_o, arb_gnt_o,
            (sram_wdata_o == 64'h0), (&sram_be_o), sram_addr_o};
  endfunction

  // Check walk cycles at indices first..last, with done flag as given.
  task automatic walk(input int first, input int last, input logic done);
    logic [7:0] idx;
    for (int i = first; i <= last; i++) begin
      @(negedge clk_i); #1;
      idx = i[7:0];
      chk($sformatf("walk[%0d]", i), {50'h0, walk_vec()}, {50'h0, 6'b111011, idx});
      chk($sformatf("walk_done[%0d]", i), {63'h0, init_done_o}, {63'h0, done});
    end
  endtask

  // In IDLE, busy low and done high.
  task automatic chk_idle(input string tag);
    @(negedge clk_i); #1;
    chk(tag, {62'h0, busy_o, init_done_o}, 64'h1);
    $display("%s: idle busy=%0b done=%0b", tag, busy_o, init_done_o);
  endtask

  initial begin
    rst_ni = 1'b0; clr_i = 1'b0; init_ni = 1'b1;
    arb_req_i = 8'h00; arb_we_i = 1'b0; arb_addr_i = 12'h000;
    arb_wdata_i = 64'h0; arb_be_i = 64'h0;

    // Reset state
    #12;
    chk("rst_vec", {50'h0, walk_vec()}, {50'h0, 6'b111011, 8'h00});
    chk("rst_done", {63'h0, init_done_o}, 64'h0);
`ifdef DCACHE_INIT_CYCLES_EN
    chk("rst_cycles", {48'h0, init_cycles_o}, 64'd0);
`endif
    $display("reset: busy=%0b done=%0b addr=%h", busy_o, init_done_o, sram_addr_o);

    // Reset walk with arbiter noise that must be ignored
    @(negedge clk_i);
    rst_ni = 1'b1;
    arb_req_i = 8'h01; arb_we_i = 1'b0; arb_addr_i = 12'hFF0;
    arb_wdata_i = 64'hDEAD; arb_be_i = 64'h0F;
    #1;
    chk("walk0_first", {50'h0, walk_vec()}, {50'h0, 6'b111011, 8'h00});
    walk(1, 255, 1'b0);
    $display("reset walk: 256 writes checked");
    chk_idle("after_reset_walk");
`ifdef DCACHE_INIT_CYCLES_EN
    chk("cycles_256", {48'h0, init_cycles_o}, 64'd256);
`endif

    // Pass-through write
    arb_req_i = 8'h04; arb_we_i = 1'b1; arb_addr_i = 12'h3A0;
    arb_wdata_i = 64'h0300; arb_be_i = 64'h0000_0000_0000_FF00;
    #1;
    chk("pt_ctl", {60'h0, sram_req_o, sram_we_o, arb_gnt_o, busy_o}, 64'hE);
    chk("pt_addr", {56'h0, sram_addr_o}, 64'h3A);
    chk("pt_wdata", sram_wdata_o, 64'h0300);
    chk("pt_be", sram_be_o, 64'hFF00);
    $display("passthru: req=%0b we=%0b gnt=%0b addr=%h", sram_req_o, sram_we_o, arb_gnt_o, sram_addr_o);

    // No request: nothing granted
    @(negedge clk_i);
    arb_req_i = 8'h00; arb_we_i = 1'b0; arb_addr_i = 12'h7F0;
    #1;
    chk("noreq_ctl", {61'h0, sram_req_o, sram_we_o, arb_gnt_o}, 64'h0);
    chk("noreq_addr", {56'h0, sram_addr_o}, 64'h7F);

    // init request from IDLE: still granted that cycle
    @(negedge clk_i);
    init_ni = 1'b0; arb_req_i = 8'h10; arb_addr_i = 12'h550;
    #1;
    chk("initreq_gnt", {61'h0, sram_req_o, arb_gnt_o, busy_o}, 64'h6);
    chk("initreq_addr", {56'h0, sram_addr_o}, 64'h55);
    @(negedge clk_i);
    init_ni = 1'b1;
    #1;
    chk("initwalk0", {50'h0, walk_vec()}, {50'h0, 6'b111011, 8'h00});
    chk("initwalk0_done", {63'h0, init_done_o}, 64'h1);
    walk(1, 99, 1'b1);

    // clr at index 100
    @(negedge clk_i);
    clr_i = 1'b1;
    #1;
    chk("clr_cycle", {50'h0, walk_vec()}, {50'h0, 6'b111011, 8'd100});
    @(negedge clk_i);
    clr_i = 1'b0;
    #1;
    chk("after_clr", {50'h0, walk_vec()}, {50'h0, 6'b111011, 8'h00});
    chk("after_clr_done", {63'h0, init_done_o}, 64'h0);
    walk(1, 255, 1'b0);
    $display("clr walk: restarted and completed");
    chk_idle("after_clr_walk");
`ifdef DCACHE_INIT_CYCLES_EN
    chk("cycles_613", {48'h0, init_cycles_o}, 64'd613);
`endif

    // init held low at final index -> immediate restart
    arb_req_i = 8'h00;
    init_ni = 1'b0;
    @(negedge clk_i);
    init_ni = 1'b1;
    #1;
    chk("hold0", {50'h0, walk_vec()}, {50'h0, 6'b111011, 8'h00});
    walk(1, 254, 1'b1);
    @(negedge clk_i);
    init_ni = 1'b0;
    #1;
    chk("hold_last", {50'h0, walk_vec()}, {50'h0, 6'b111011, 8'd255});
    @(negedge clk_i);
    init_ni = 1'b1;
    #1;
    chk("restart0", {50'h0, walk_vec()}, {50'h0, 6'b111011, 8'h00});
    chk("restart_done", {63'h0, init_done_o}, 64'h1);
    walk(1, 255, 1'b1);
    $display("init held at last index: second walk completed");
    chk_idle("after_restart");
`ifdef DCACHE_INIT_CYCLES_EN
    chk("cycles_1125", {48'h0, init_cycles_o}, 64'd1125);
`endif

    // Reset mid-walk at index 50 with arbiter requesting
    init_ni = 1'b0;
    @(negedge clk_i);
    init_ni = 1'b1;
    #1;
    walk(1, 49, 1'b1);
    @(negedge clk_i);
    arb_req_i = 8'hFF; arb_we_i = 1'b0;
    #1;
    chk("pre_rst", {50'h0, walk_vec()}, {50'h0, 6'b111011, 8'd50});
    #1;
    rst_ni = 1'b0;
    #1;
    chk("async_rst", {50'h0, walk_vec()}, {50'h0, 6'b111011, 8'h00});
    chk("async_rst_done", {63'h0, init_done_o}, 64'h0);
`ifdef DCACHE_INIT_CYCLES_EN
    chk("async_rst_cycles", {48'h0, init_cycles_o}, 64'd0);
`endif
    $display("async reset mid-walk: addr=%h gnt=%0b", sram_addr_o, arb_gnt_o);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rst_walk0", {50'h0, walk_vec()}, {50'h0, 6'b111011, 8'h00});
    walk(1, 255, 1'b0);
    chk_idle("after_rst_walk");
    chk("idle_gnt", {63'h0, arb_gnt_o}, 64'h1);

`ifdef DCACHE_INIT_CYCLES_EN
    // reset walk + init walk with a clr in between keeps counting
    arb_req_i = 8'h00;
    init_ni = 1'b0;
    @(negedge clk_i);
    init_ni = 1'b1;
    walk(1, 9, 1'b1);
    @(negedge clk_i);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    #1;
    chk("cnt_clr_cycles", {48'h0, init_cycles_o}, 64'd267);
    walk(1, 255, 1'b0);
    chk_idle("after_cnt_walk");
    chk("cycles_523", {48'h0, init_cycles_o}, 64'd523);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
